// File: rtl/id_stage_pkg.sv
// Shared opcode map, field positions, operand-use lists and decode payload for the ID stage.
package id_stage_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned RA_W     = 3;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned INSTR_W  = 16;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned RS1_LSB  = 6;
  localparam int unsigned RS2_LSB  = 3;
  localparam int unsigned IMM6_W   = 6;
  localparam int unsigned IMM12_W  = 12;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OP_W-1:0] OP_LD   = 4'h5;
  localparam logic [OP_W-1:0] OP_ST   = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OP_W-1:0] OP_NOP  = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  // Opcodes with a defined meaning; everything else is treated as NOP
  function automatic logic is_defined_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST,
      OP_BEQ, OP_JMP, OP_NOP, OP_HLT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Opcodes that read the rs1 port
  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

  // Opcodes that read the rs2 port
  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Decoded view of one instruction
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [DATA_W-1:0] imm6;
    logic [DATA_W-1:0] imm12;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              use_rs1;
    logic              use_rs2;
    logic              is_beq;
    logic              is_jmp;
    logic              is_hlt;
  } id_dec_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: register addresses, immediates, control bits, operand-use flags.
module id_decode
  import id_stage_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output id_dec_t            o_dec_c
);

  logic [OP_W-1:0] w_raw_op;
  logic [OP_W-1:0] w_op;

  assign w_raw_op = i_instr[OP_LSB +: OP_W];
  assign w_op     = is_defined_op(w_raw_op) ? w_raw_op : OP_NOP;

  // Field extraction and control decode; undefined opcodes fall out as NOP
  always_comb begin
    o_dec_c         = '0;
    o_dec_c.op      = w_op;
    o_dec_c.rd      = i_instr[RD_LSB  +: RA_W];
    o_dec_c.rs1     = i_instr[RS1_LSB +: RA_W];
    // ST and BEQ carry their second source in the rd field
    o_dec_c.rs2     = (w_op == OP_ST || w_op == OP_BEQ) ? i_instr[RD_LSB +: RA_W]
                                                        : i_instr[RS2_LSB +: RA_W];
    o_dec_c.imm6    = {{(DATA_W-IMM6_W){i_instr[IMM6_W-1]}}, i_instr[IMM6_W-1:0]};
    o_dec_c.imm12   = {{(DATA_W-IMM12_W){i_instr[IMM12_W-1]}}, i_instr[IMM12_W-1:0]};
    o_dec_c.use_rs1 = uses_rs1(w_op);
    o_dec_c.use_rs2 = uses_rs2(w_op);
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: o_dec_c.reg_write = 1'b1;
      OP_LD: begin
        o_dec_c.reg_write = 1'b1;
        o_dec_c.mem_read  = 1'b1;
      end
      OP_ST:   o_dec_c.mem_write = 1'b1;
      OP_BEQ:  o_dec_c.is_beq    = 1'b1;
      OP_JMP:  o_dec_c.is_jmp    = 1'b1;
      OP_HLT:  o_dec_c.is_hlt    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, operand read, load-use stall, BEQ/JMP redirect, halt latch, ID/EX register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  output logic [RA_W-1:0]   rs1_addr,
  output logic [RA_W-1:0]   rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              stall_if,
  output logic              flush_if,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              halt,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_pc,
  output logic [OP_W-1:0]   idex_op,
  output logic [RA_W-1:0]   idex_rd,
  output logic [DATA_W-1:0] idex_a,
  output logic [DATA_W-1:0] idex_b,
  output logic [DATA_W-1:0] idex_imm,
  output logic              idex_reg_write,
  output logic              idex_mem_read,
  output logic              idex_mem_write
);

  logic               r_id_valid;
  logic [DATA_W-1:0]  r_id_pc;
  logic [INSTR_W-1:0] r_id_instr;
  logic               r_halt;

  logic               r_idex_valid;
  logic [DATA_W-1:0]  r_idex_pc;
  logic [OP_W-1:0]    r_idex_op;
  logic [RA_W-1:0]    r_idex_rd;
  logic [DATA_W-1:0]  r_idex_a;
  logic [DATA_W-1:0]  r_idex_b;
  logic [DATA_W-1:0]  r_idex_imm;
  logic               r_idex_reg_write;
  logic               r_idex_mem_read;
  logic               r_idex_mem_write;

  id_dec_t            w_dec;
  logic               w_rs1_hit;
  logic               w_rs2_hit;
  logic               w_hazard;
  logic               w_br_ok;
  logic               w_taken;
  logic [DATA_W-1:0]  w_br_off;
  logic               w_bubble;
  logic               w_halt_set;

  id_decode u_decode (
    .i_instr (r_id_instr),
    .o_dec_c (w_dec)
  );

  // Load-use: the load sitting in ID/EX writes a register the instruction in ID reads
  assign w_rs1_hit  = w_dec.use_rs1 && (r_idex_rd == w_dec.rs1);
  assign w_rs2_hit  = w_dec.use_rs2 && (r_idex_rd == w_dec.rs2);
  assign w_hazard   = r_id_valid && r_idex_valid && r_idex_mem_read &&
                      (r_idex_rd != '0) && (w_rs1_hit || w_rs2_hit);

  // Branch resolves only once its operands are valid and the core is running
  assign w_br_ok    = r_id_valid && !w_hazard && !r_halt;
  assign w_taken    = w_br_ok && ((w_dec.is_beq && (rs1_data == rs2_data)) || w_dec.is_jmp);
  assign w_br_off   = w_dec.is_jmp ? w_dec.imm12 : w_dec.imm6;

  assign w_bubble   = r_halt || w_hazard || !r_id_valid;
  assign w_halt_set = r_id_valid && w_dec.is_hlt && !w_hazard;

  assign rs1_addr       = w_dec.rs1;
  assign rs2_addr       = w_dec.rs2;
  assign stall_if       = w_hazard;
  assign flush_if       = w_taken;
  assign branch_taken   = w_taken;
  assign branch_target  = w_taken ? (r_id_pc + DATA_W'(1) + w_br_off) : '0;
  assign halt           = r_halt;

  assign idex_valid     = r_idex_valid;
  assign idex_pc        = r_idex_pc;
  assign idex_op        = r_idex_op;
  assign idex_rd        = r_idex_rd;
  assign idex_a         = r_idex_a;
  assign idex_b         = r_idex_b;
  assign idex_imm       = r_idex_imm;
  assign idex_reg_write = r_idex_reg_write;
  assign idex_mem_read  = r_idex_mem_read;
  assign idex_mem_write = r_idex_mem_write;

  // IF/ID register: hold on halt or stall, squash on redirect, else load from fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_instr <= '0;
    end else if (r_halt || w_hazard) begin
      r_id_valid <= r_id_valid;
    end else if (w_taken) begin
      r_id_valid <= 1'b0;
    end else begin
      r_id_valid <= 1'b1;
      r_id_pc    <= if_pc;
      r_id_instr <= if_instr;
    end
  end

  // Sticky halt, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (w_halt_set) begin
      r_halt <= 1'b1;
    end
  end

  // ID/EX register: bubble on stall, halt or empty ID, else capture decoded instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex_valid     <= 1'b0;
      r_idex_pc        <= '0;
      r_idex_op        <= '0;
      r_idex_rd        <= '0;
      r_idex_a         <= '0;
      r_idex_b         <= '0;
      r_idex_imm       <= '0;
      r_idex_reg_write <= 1'b0;
      r_idex_mem_read  <= 1'b0;
      r_idex_mem_write <= 1'b0;
    end else if (w_bubble) begin
      r_idex_valid     <= 1'b0;
      r_idex_pc        <= '0;
      r_idex_op        <= '0;
      r_idex_rd        <= '0;
      r_idex_a         <= '0;
      r_idex_b         <= '0;
      r_idex_imm       <= '0;
      r_idex_reg_write <= 1'b0;
      r_idex_mem_read  <= 1'b0;
      r_idex_mem_write <= 1'b0;
    end else begin
      r_idex_valid     <= 1'b1;
      r_idex_pc        <= r_id_pc;
      r_idex_op        <= w_dec.op;
      r_idex_rd        <= w_dec.rd;
      r_idex_a         <= rs1_data;
      r_idex_b         <= rs2_data;
      r_idex_imm       <= w_dec.imm6;
      r_idex_reg_write <= w_dec.reg_write;
      r_idex_mem_read  <= w_dec.mem_read;
      r_idex_mem_write <= w_dec.mem_write;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: architectural path model feeds a scoreboard checked by a monitor.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam int unsigned IMEM_N      = 64;
  localparam int unsigned MAX_ENTRIES = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       if_pc;
  logic [15:0]       if_instr;
  logic [RA_W-1:0]   rs1_addr, rs2_addr;
  logic [15:0]       rs1_data, rs2_data;
  logic              stall_if, flush_if, branch_taken, halt;
  logic [15:0]       branch_target;
  logic              idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
  logic [15:0]       idex_pc, idex_a, idex_b, idex_imm;
  logic [3:0]        idex_op;
  logic [RA_W-1:0]   idex_rd;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall_if(stall_if), .flush_if(flush_if), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_op(idex_op), .idex_rd(idex_rd),
    .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write)
  );

  // Instruction memory and (already forwarded) register file seen by the stage
  logic [15:0] imem [IMEM_N];
  logic [15:0] regs [8];
  assign if_instr = imem[if_pc[5:0]];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b, imm;
    logic        rw, mr, mw;
    int          at_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] tgt_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          exp_stalls = 0;
  int          last_at = 0;
  bit          mon_on = 1'b0;
  bit          capped = 1'b0;
  bit          exp_halt = 1'b0;
  logic [15:0] start_pc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sx6(input logic [15:0] ins);
    return {{10{ins[5]}}, ins[5:0]};
  endfunction

  function automatic logic [15:0] sx12(input logic [15:0] ins);
    return {{4{ins[11]}}, ins[11:0]};
  endfunction

  // Architectural opcode: 0..8, E, F are defined, the rest behave as NOP
  function automatic logic [3:0] opn(input logic [15:0] ins);
    logic [3:0] o;
    o = ins[15:12];
    return (o <= 4'h8 || o >= 4'hE) ? o : 4'hE;
  endfunction

  function automatic logic [2:0] rs2f(input logic [15:0] ins);
    logic [3:0] o;
    o = opn(ins);
    return (o == 4'h6 || o == 4'h7) ? ins[11:9] : ins[5:3];
  endfunction

  function automatic bit use1(input logic [3:0] o);
    return o <= 4'h7;
  endfunction

  function automatic bit use2(input logic [3:0] o);
    return o <= 4'h3 || o == 4'h6 || o == 4'h7;
  endfunction

  // Walk the program in architectural order and predict each ID/EX entry and its arrival cycle
  task automatic build_model();
    logic [15:0] pc, ins;
    logic [3:0]  op;
    logic [2:0]  prev_rd;
    bit          prev_ld, prev_taken, haz;
    int          at, n;
    exp_t        e;
    exp_q.delete();
    tgt_q.delete();
    pc = start_pc; prev_ld = 0; prev_rd = '0; prev_taken = 0;
    at = 2; n = 0; exp_stalls = 0; exp_halt = 0;
    while (n < int'(MAX_ENTRIES)) begin
      ins = imem[pc[5:0]];
      op  = opn(ins);
      if (n > 0) at = at + 1 + (prev_taken ? 1 : 0);
      haz = prev_ld && (prev_rd != 3'd0) &&
            ((use1(op) && ins[8:6] == prev_rd) || (use2(op) && rs2f(ins) == prev_rd));
      if (haz) begin
        at++;
        exp_stalls++;
      end
      e.pc = pc; e.op = op; e.rd = ins[11:9];
      e.a = regs[ins[8:6]]; e.b = regs[rs2f(ins)]; e.imm = sx6(ins);
      e.rw = (op <= 4'h5); e.mr = (op == 4'h5); e.mw = (op == 4'h6);
      e.at_cyc = at;
      exp_q.push_back(e);
      last_at = at;
      n++;
      prev_ld = (op == 4'h5); prev_rd = ins[11:9]; prev_taken = 0;
      if (op == 4'hF) begin
        exp_halt = 1;
        break;
      end
      if (op == 4'h7 && regs[ins[8:6]] == regs[ins[11:9]]) begin
        pc = pc + 16'd1 + sx6(ins);
        prev_taken = 1;
        tgt_q.push_back(pc);
      end else if (op == 4'h8) begin
        pc = pc + 16'd1 + sx12(ins);
        prev_taken = 1;
        tgt_q.push_back(pc);
      end else begin
        pc = pc + 16'd1;
      end
    end
    capped = !exp_halt;
  endtask

  // Monitor: compare every DUT output event against the scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc == 1) begin
        logic [15:0] ins0;
        ins0 = imem[start_pc[5:0]];
        check("rs1_addr", 128'(rs1_addr), 128'(ins0[8:6]));
        check("rs2_addr", 128'(rs2_addr), 128'(rs2f(ins0)));
      end
      if (idex_valid) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("idex_fields",
                {idex_pc, idex_op, idex_rd, idex_a, idex_b, idex_imm,
                 idex_reg_write, idex_mem_read, idex_mem_write},
                {mon_e.pc, mon_e.op, mon_e.rd, mon_e.a, mon_e.b, mon_e.imm,
                 mon_e.rw, mon_e.mr, mon_e.mw});
          check("idex_cycle", 128'(cyc), 128'(mon_e.at_cyc));
        end else if (!capped) begin
          check("idex_extra", 128'(idex_valid), 128'(0));
        end
      end
      if (flush_if) begin
        check("taken_eq_flush", 128'(branch_taken), 128'(1));
        if (tgt_q.size() > 0) check("branch_target", 128'(branch_target), 128'(tgt_q.pop_front()));
        else if (!capped)     check("flush_extra", 128'(flush_if), 128'(0));
      end else begin
        check("target_idle", {branch_taken, branch_target}, 128'(0));
      end
      if (stall_if) stall_cnt++;
    end
  end

  // Reset, then act as the fetch stage for a bounded number of cycles
  task automatic run_prog();
    logic [15:0] nxt;
    mon_on = 0;
    rst = 1'b1;
    if_pc = start_pc;
    regs[0] = 16'h0000;
    build_model();
    #1;
    check("rst_halt", 128'(halt), 128'(0));
    check("rst_idex", {idex_valid, idex_pc, idex_op, idex_reg_write, idex_mem_read, idex_mem_write}, 128'(0));
    check("rst_ctl", {stall_if, flush_if}, 128'(0));
    @(negedge clk);
    cyc = 0; stall_cnt = 0;
    rst = 1'b0;
    mon_on = 1;
    repeat (last_at + 4) begin
      nxt = stall_if ? if_pc : (flush_if ? branch_target : if_pc + 16'd1);
      @(posedge clk);
      cyc++;
      #1 if_pc = nxt;
      @(negedge clk);
    end
    #2;
    mon_on = 0;
    check("exp_drain", 128'(exp_q.size()), 128'(0));
    check("tgt_drain", 128'(tgt_q.size()), 128'(0));
    if (exp_halt) begin
      check("halt_set", 128'(halt), 128'(1));
      check("halt_bubble", 128'(idex_valid), 128'(0));
      check("stall_cycles", 128'(stall_cnt), 128'(exp_stalls));
    end
    rst = 1'b1;
    #1;
    check("async_rst_halt", 128'(halt), 128'(0));
    check("async_rst_idex", {idex_valid, stall_if, flush_if}, 128'(0));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < int'(IMEM_N); i++) imem[i] = 16'hE000;
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0111);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom)};
  endfunction

  initial begin
    rst = 1'b1;
    if_pc = '0;
    start_pc = '0;
    clear_mem();

    // ADD r1,r2,r3 then HLT
    clear_mem(); start_pc = 16'h0000;
    imem[0] = 16'h0298; imem[1] = 16'hF000;
    run_prog();

    // LD r1,0(r2) ; ADD r4,r1,r5 : one load-use stall
    clear_mem(); start_pc = 16'h0000;
    imem[0] = 16'h5280; imem[1] = 16'h0868; imem[2] = 16'hF000;
    run_prog();

    // BEQ r1,r2,+4 at 0x0010, taken
    clear_mem(); start_pc = 16'h0010;
    regs[1] = 16'h00AA; regs[2] = 16'h00AA;
    imem[16] = 16'h7284; imem[17] = 16'h0298; imem[18] = 16'hF000; imem[21] = 16'hF000;
    run_prog();

    // Same BEQ, not taken
    clear_mem(); start_pc = 16'h0010;
    regs[1] = 16'h00AB; regs[2] = 16'h00AA;
    imem[16] = 16'h7284; imem[17] = 16'h0298; imem[18] = 16'hF000; imem[21] = 16'hF000;
    run_prog();

    // JMP +3 at 0xFFFE wraps to 0x0002
    clear_mem(); start_pc = 16'hFFFE;
    imem[62] = 16'h8003; imem[63] = 16'h0298; imem[2] = 16'hF000;
    run_prog();

    // Random programs with small register values so branches and hazards are common
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < int'(IMEM_N); i++) imem[i] = rand_instr();
      for (int i = 1; i < 8; i++)
        regs[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      start_pc = 16'($urandom);
      run_prog();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
